seq_checker: RTL and testbench
==============================

# seq_checker

Receive-side companion of the two-register pattern sequencer: samples a 4-bit data bus on a one-cycle sample strobe, hunts for the alternating PAT0/PAT1 sequence, and declares lock after LOCK_N consecutive correct samples. Once locked, any out-of-sequence sample raises an error pulse, increments a saturating error counter and forces a re-hunt. It sits on the sequencer's data output, in the same clock domain, sharing the sequencer's prescaler tick.

## Interface
- PAT0, 4'b1010, first pattern of the alternating sequence
- PAT1, 4'b0101, second pattern; PAT1 != PAT0 is required
- LOCK_N, 4, consecutive correct samples needed to lock (range 2..15)
- ERR_W, 8, error counter width
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset, synchronous, active-high
- tick  input  1  sample strobe, one clk cycle wide; din is sampled only when tick=1
- din  input  4  data from the sequencer
- locked  output  1  high while in LOCKED
- error  output  1  one-cycle pulse per detected sequence break
- alarm  output  1  error indicator; behaviour is set by the macro in Configuration
- err_count  output  ERR_W  number of sequence breaks, saturating

## Operation
- States: HUNT, VERIFY, LOCKED. Internal registers: exp (4 bits, expected next value) and run (4-bit match counter).
- HUNT, tick:
  - din==PAT0: exp<=PAT1, run<=1, go to VERIFY.
  - din==PAT1: exp<=PAT0, run<=1, go to VERIFY.
  - otherwise: stay in HUNT.
- VERIFY, tick, din==exp: exp toggles and run increments. When run reaches LOCK_N (the increment takes run from LOCK_N-1 to LOCK_N), go to LOCKED.
- VERIFY, tick, din!=exp: behave as HUNT on the same sample (re-seed if din is a pattern, otherwise HUNT). No error is raised.
- LOCKED, tick, din==exp: exp toggles and the state stays LOCKED.
- LOCKED, tick, din!=exp:
  - error=1 for one cycle.
  - err_count increments, saturating at 2^ERR_W-1.
  - Go to HUNT and clear run. The bad sample is not reused for seeding.
- tick=0: no state, exp, run or counter change. error is 0 in any cycle without a break.
- Errors are counted only from LOCKED. Garbage before the first lock is silent.
- Reset (valid mid-operation, and it overrides tick):
  - state=HUNT, exp=PAT0, run=0.
  - locked=0, error=0, alarm=0, err_count=0.

## Timing
- All outputs are registered.
- A tick sample at edge N is reflected on locked, error and err_count after edge N, so it is visible in cycle N+1.
- With ticks on consecutive cycles, lock is reached at the LOCK_N-th correct sample, i.e. locked rises after the edge that samples the LOCK_N-th matching value.
- Back-to-back ticks are legal. Each one is evaluated independently.
- When rst and tick are both high, rst wins and the sample is discarded.
- locked falls on the same edge that asserts error.

## Configuration
- SEQ_CHECKER_STICKY_ALARM_EN defined:
  - alarm sets on the first error and holds until rst.
  - Further errors keep it high.
- Not defined:
  - alarm is combinationally equal to error, i.e. a one-cycle pulse.
- No other behaviour changes.

## Structure
- Shared header seq_defs.vh holds:
  - state encodings (HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2);
  - default pattern constants 4'b1010 and 4'b0101;
  - LOCK_N default.
- The sequencer and the checker both include it so the pattern defaults match.
- One sub-module: sat_counter, an ERR_W-wide saturating incrementer with sync reset and an inc enable, instantiated for err_count.

## Test plan
- Ticks every 4 clk with din alternating 1010,0101 from reset -> locked rises after the 4th tick sample; err_count=0; error never pulses.
- While locked, feed 1010 twice in a row -> on the second sample error pulses once, locked=0, err_count=1. Re-sending the alternation relocks after 4 samples.
- Before any lock, feed 0000,1010,1111,0101,1010,0101,1010 -> no error. Lock occurs only after the final 4 correct samples (0101,1010,0101,1010).
- Force 300 breaks with ERR_W=8 -> err_count saturates at 255 and error still pulses on each break.
- Assert rst for one cycle while locked and simultaneously with a bad tick sample -> all outputs 0 after the edge, state=HUNT, no error pulse.
- With SEQ_CHECKER_STICKY_ALARM_EN, one break then a relock -> alarm stays 1 until rst. Without the macro -> alarm is a one-cycle pulse aligned with error.

Source files
------------

// File: rtl/seq_checker_pkg.sv
// Shared definitions for the pattern sequencer and its checker: state encodings,
// default pattern constants and the default lock length.
package seq_checker_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] PAT0_DEF   = 4'b1010;
  localparam logic [3:0] PAT1_DEF   = 4'b0101;
  localparam int         LOCK_N_DEF = 4;
  localparam int         ERR_W_DEF  = 8;

  // The other half of the alternating pair; only meaningful when cur is a pattern.
  function automatic logic [3:0] other_pat(input logic [3:0] cur,
                                           input logic [3:0] p0,
                                           input logic [3:0] p1);
    return (cur == p0) ? p1 : p0;
  endfunction

endpackage

// File: rtl/seq_checker_sat_counter.sv
// sat_counter: W-bit incrementer that sticks at all-ones; synchronous reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_checker.sv
// Alternating-pattern lock checker with saturating break counter.
// SEQ_CHECKER_STICKY_ALARM_EN makes alarm latch on the first break until reset.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter logic [3:0] PAT0   = PAT0_DEF,
  parameter logic [3:0] PAT1   = PAT1_DEF,
  parameter int         LOCK_N = LOCK_N_DEF,
  parameter int         ERR_W  = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [3:0]       din,
  output logic             locked,
  output logic             error,
  output logic             alarm,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

  state_e     state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] run_q, run_d;
  logic       error_q, error_d;
  logic [3:0] run_inc;

  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    error_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        LOCKED: begin
          if (din == exp_q) begin
            exp_d = other_pat(exp_q, PAT0, PAT1);
          end else begin
            // The offending sample is dropped rather than used to re-seed.
            error_d = 1'b1;
            state_d = HUNT;
            run_d   = 4'd0;
          end
        end
        VERIFY, HUNT: begin
          if ((state_q == VERIFY) && (din == exp_q)) begin
            exp_d = other_pat(exp_q, PAT0, PAT1);
            run_d = run_inc;
            if (run_inc == LOCK_RUN) begin
              state_d = LOCKED;
            end
          end else if ((din == PAT0) || (din == PAT1)) begin
            exp_d   = other_pat(din, PAT0, PAT1);
            run_d   = 4'd1;
            state_d = VERIFY;
          end else begin
            state_d = HUNT;
            run_d   = 4'd0;
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= PAT0;
      run_q   <= 4'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      error_q <= error_d;
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (error_d),
    .count_o (err_count)
  );

  assign locked = (state_q == LOCKED);
  assign error  = error_q;

`ifdef SEQ_CHECKER_STICKY_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else if (error_d) begin
      alarm_q <= 1'b1;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = error_q;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: run-length reference model plus directed
// and random stimulus.
module tb_seq_checker;

  localparam logic [3:0] P0 = 4'b1010;
  localparam logic [3:0] P1 = 4'b0101;
  localparam int         LN = 4;
  localparam int         EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [3:0]    din;
  logic          locked;
  logic          error;
  logic          alarm;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  seq_checker #(
    .PAT0   (P0),
    .PAT1   (P1),
    .LOCK_N (LN),
    .ERR_W  (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .din       (din),
    .locked    (locked),
    .error     (error),
    .alarm     (alarm),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the samples seen since the last reset or break. The checker is
  // locked exactly when the trailing alternating-pattern run is at least LN long.
  logic [3:0] seg[$];
  bit m_error  = 1'b0;
  bit m_alarm  = 1'b0;
  bit m_locked = 1'b0;
  int m_cnt    = 0;
  bit started  = 1'b0;

  function automatic bit is_pat(input logic [3:0] v);
    return (v == P0) || (v == P1);
  endfunction

  function automatic int tail_len();
    int n = 0;
    for (int i = seg.size() - 1; i >= 0; i--) begin
      if (!is_pat(seg[i])) break;
      if ((i < seg.size() - 1) && (seg[i] == seg[i+1])) break;
      n++;
    end
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        seg.delete();
        m_error  = 1'b0;
        m_alarm  = 1'b0;
        m_locked = 1'b0;
        m_cnt    = 0;
        started  = 1'b1;
      end else begin
        m_error = 1'b0;
        if (tick) begin
          if (m_locked && !(is_pat(din) && (din != seg[seg.size()-1]))) begin
            m_error = 1'b1;
            if (m_cnt < (1 << EW) - 1) m_cnt++;
            seg.delete();
          end else begin
            seg.push_back(din);
            if (seg.size() > 20) void'(seg.pop_front());
          end
          m_locked = (tail_len() >= LN);
        end
`ifdef SEQ_CHECKER_STICKY_ALARM_EN
        m_alarm = m_alarm | m_error;
`else
        m_alarm = m_error;
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cyc_locked", {31'd0, locked}, {31'd0, m_locked});
        chk("cyc_error", {31'd0, error}, {31'd0, m_error});
        chk("cyc_alarm", {31'd0, alarm}, {31'd0, m_alarm});
        chk("cyc_err_count", {24'd0, err_count}, m_cnt);
      end
    end
  end

  // Called at a negedge; returns at a negedge where the sample's effect is visible.
  task automatic send(input logic [3:0] v, input int gap);
    tick = 1'b1;
    din  = v;
    @(negedge clk);
    tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] garbage[7] = '{4'b0000, 4'b1010, 4'b1111, 4'b0101, 4'b1010, 4'b0101, 4'b1010};
  logic [3:0] last_pat;
  int r;

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    din  = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_alarm", {31'd0, alarm}, 0);
    chk("rst_count", {24'd0, err_count}, 0);

    // Slow alternation locks on the 4th sample.
    send(P0, 4); send(P1, 4); send(P0, 4);
    chk("lock_before_4th", {31'd0, locked}, 0);
    send(P1, 4);
    chk("lock_after_4th", {31'd0, locked}, 1);
    chk("lock_count", {24'd0, err_count}, 0);

    // Repeated PAT0 while locked breaks the sequence.
    send(P0, 4);
    send(P0, 1);
    chk("break_error", {31'd0, error}, 1);
    chk("break_locked", {31'd0, locked}, 0);
    chk("break_count", {24'd0, err_count}, 1);
    chk("break_alarm", {31'd0, alarm}, 1);
    send(P1, 1);
    chk("break_error_once", {31'd0, error}, 0);
    send(P0, 1); send(P1, 1);
    chk("relock_before", {31'd0, locked}, 0);
    send(P0, 1);
    chk("relock_after", {31'd0, locked}, 1);
`ifdef SEQ_CHECKER_STICKY_ALARM_EN
    chk("alarm_sticky", {31'd0, alarm}, 1);
`else
    chk("alarm_pulse", {31'd0, alarm}, 0);
`endif

    // Garbage before the first lock is silent.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(garbage[i], 2);
      if (i == 5) chk("garbage_not_locked", {31'd0, locked}, 0);
    end
    chk("garbage_locked", {31'd0, locked}, 1);
    chk("garbage_count", {24'd0, err_count}, 0);

    // Saturation: 300 lock/break cycles with back-to-back ticks.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(P0, 1); send(P1, 1); send(P0, 1); send(P1, 1);
      send(P1, 1);
    end
    chk("sat_count", {24'd0, err_count}, 255);
    chk("sat_error", {31'd0, error}, 1);

    // Reset coinciding with a bad sample while locked.
    do_reset();
    send(P1, 1); send(P0, 1); send(P1, 1); send(P0, 1);
    chk("pre_rst_locked", {31'd0, locked}, 1);
    rst  = 1'b1;
    tick = 1'b1;
    din  = 4'b1111;
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    chk("rst_tick_locked", {31'd0, locked}, 0);
    chk("rst_tick_error", {31'd0, error}, 0);
    chk("rst_tick_alarm", {31'd0, alarm}, 0);
    chk("rst_tick_count", {24'd0, err_count}, 0);
    send(P0, 1); send(P1, 1); send(P0, 1);
    chk("post_rst_hunt", {31'd0, locked}, 0);
    send(P1, 1);
    chk("post_rst_lock", {31'd0, locked}, 1);

    // Random traffic, including back-to-back ticks and occasional resets.
    last_pat = P0;
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      tick = ($urandom_range(0, 2) != 0);
      r    = $urandom_range(0, 9);
      if (r < 7)      din = (last_pat == P0) ? P1 : P0;
      else if (r < 9) din = ($urandom_range(0, 1) == 0) ? P0 : P1;
      else            din = 4'($urandom_range(0, 15));
      if (tick && is_pat(din)) last_pat = din;
      @(negedge clk);
    end
    rst  = 1'b0;
    tick = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
